// File: rtl/ps2_device.sv
// Device-side PS/2 engine: generates the PS/2 clock, sends scan codes and receives host commands.
// Optional feature macro PS2_DEVICE_RESEND_EN: a bad received frame queues an automatic 0xFE.
module ps2_device #(
   parameter int unsigned HALF_PERIOD = 2072,
   parameter int unsigned IDLE_CYCLES = 2590
) (
   input  logic       clk,
   input  logic       reset_low,
   input  logic       ps2_clk_in,
   output logic       ps2_clk_out,
   output logic       ps2_clk_oe,
   input  logic       ps2_data_in,
   output logic       ps2_data_out,
   output logic       ps2_data_oe,
   input  logic       scan_code_valid,
   output logic       scan_code_ready,
   input  logic [7:0] scan_code_byte,
   output logic       command_valid,
   input  logic       command_ready,
   output logic [7:0] command_byte,
   output logic       error
);

   localparam int unsigned TimerW = $clog2(HALF_PERIOD);
   localparam int unsigned IdleW  = $clog2(IDLE_CYCLES + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(HALF_PERIOD - 1);
   localparam logic [IdleW-1:0]  IdleMax   = IdleW'(IDLE_CYCLES);

   typedef enum logic [2:0] {StIdle, StTx, StRxClock, StAck, StHold} state_e;

   state_e state_q, state_d;

   logic              clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              phase_q, phase_d;       // 0 = HIGH phase, 1 = LOW phase
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
   logic              low_seen_q, low_seen_d;
   logic [7:0]        hold_q, hold_d;
   logic              full_q, full_d;
   logic [9:0]        shift_q, shift_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [7:0]        cmd_byte_q, cmd_byte_d;
   logic              error_q, error_d;
   logic              clk_oe_q, clk_oe_d;
   logic              data_oe_q, data_oe_d;
   logic              ready_q, ready_d;
`ifdef PS2_DEVICE_RESEND_EN
   logic              resend_q, resend_d;
   logic              tx_resend_q, tx_resend_d;
`endif

   logic        half_end, accept, clocked, tx_bit, frame_ok, tx_pending, tx_finish;
   logic [7:0]  tx_byte;
   logic [15:0] tx_frame;

   assign ps2_clk_out     = 1'b0;
   assign ps2_data_out    = 1'b0;
   assign ps2_clk_oe      = clk_oe_q;
   assign ps2_data_oe     = data_oe_q;
   assign scan_code_ready = ready_q;
   assign command_valid   = cmd_valid_q;
   assign command_byte    = cmd_byte_q;
   assign error           = error_q;

   assign half_end = (timer_q == TimerLast);
   assign accept   = scan_code_valid & ready_q;
   assign clocked  = (state_q == StTx) || (state_q == StRxClock) || (state_q == StAck);

`ifdef PS2_DEVICE_RESEND_EN
   assign tx_pending = full_q | resend_q;
   assign tx_byte    = tx_resend_q ? 8'hFE : hold_q;
`else
   assign tx_pending = full_q;
   assign tx_byte    = hold_q;
`endif

   // Frame bit order on the wire: start, data LSB first, odd parity, stop.
   assign tx_frame = {5'b11111, 1'b1, ~(^tx_byte), tx_byte, 1'b0};
   assign tx_bit   = tx_frame[bit_cnt_q];
   assign frame_ok = (^shift_q[8:0]) & shift_q[9];

   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk_in;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data_in;
         data_sync_q <= data_meta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      phase_d     = phase_q;
      bit_cnt_d   = bit_cnt_q;
      idle_cnt_d  = '0;
      low_seen_d  = 1'b0;
      hold_d      = hold_q;
      full_d      = full_q;
      shift_d     = shift_q;
      cmd_valid_d = cmd_valid_q;
      cmd_byte_d  = cmd_byte_q;
      error_d     = 1'b0;
      tx_finish   = 1'b0;
`ifdef PS2_DEVICE_RESEND_EN
      resend_d    = resend_q;
      tx_resend_d = tx_resend_q;
`endif

      if (cmd_valid_q && command_ready) cmd_valid_d = 1'b0;
      if (accept) begin
         hold_d = scan_code_byte;
         full_d = 1'b1;
      end

      if (clocked) begin
         if (half_end) begin
            timer_d = '0;
            phase_d = ~phase_q;
            if (phase_q) bit_cnt_d = bit_cnt_q + 4'd1;
         end else begin
            timer_d = timer_q + TimerW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (clk_sync_q && data_sync_q) begin
               idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
            end
            low_seen_d = !clk_sync_q || (low_seen_q && !data_sync_q);
            if (low_seen_q && clk_sync_q && !data_sync_q) begin
               state_d = StRxClock;
            end else if (tx_pending && idle_cnt_q == IdleMax) begin
               state_d = StTx;
`ifdef PS2_DEVICE_RESEND_EN
               tx_resend_d = resend_q;
`endif
            end
         end
         StTx: begin
            // Host holding the clock low at the end of a HIGH phase is an inhibit.
            if (half_end && !phase_q && !clk_sync_q) begin
               if (bit_cnt_q == 4'd10) tx_finish = 1'b1;
               else                    state_d   = StHold;
            end else if (half_end && phase_q && bit_cnt_q == 4'd10) begin
               tx_finish = 1'b1;
            end
         end
         StHold: begin
            if (clk_sync_q) state_d = data_sync_q ? StIdle : StRxClock;
         end
         StRxClock: begin
            if (half_end && !phase_q) shift_d = {data_sync_q, shift_q[9:1]};
            if (half_end && phase_q && bit_cnt_q == 4'd9) state_d = StAck;
         end
         StAck: begin
            if (half_end && phase_q) begin
               state_d = StIdle;
               if (frame_ok) begin
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = shift_q[7:0];
               end else begin
                  error_d = 1'b1;
`ifdef PS2_DEVICE_RESEND_EN
                  resend_d = 1'b1;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (tx_finish) begin
         state_d = StIdle;
`ifdef PS2_DEVICE_RESEND_EN
         if (tx_resend_q) resend_d = 1'b0;
         else             full_d   = 1'b0;
`else
         full_d = 1'b0;
`endif
      end

      // Every state change starts the bit timer afresh at a HIGH phase.
      if (state_d != state_q) begin
         timer_d   = '0;
         phase_d   = 1'b0;
         bit_cnt_d = '0;
      end

      clk_oe_d  = clocked && phase_q;
      data_oe_d = ((state_q == StTx) && !tx_bit) || (state_q == StAck);
      // Drop ready in the accepting cycle so the same byte is never taken twice.
      ready_d   = !full_q && !accept;
   end

   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         phase_q     <= 1'b0;
         bit_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         low_seen_q  <= 1'b0;
         hold_q      <= '0;
         full_q      <= 1'b0;
         shift_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= '0;
         error_q     <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         ready_q     <= 1'b0;
`ifdef PS2_DEVICE_RESEND_EN
         resend_q    <= 1'b0;
         tx_resend_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         phase_q     <= phase_d;
         bit_cnt_q   <= bit_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         low_seen_q  <= low_seen_d;
         hold_q      <= hold_d;
         full_q      <= full_d;
         shift_q     <= shift_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         error_q     <= error_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         ready_q     <= ready_d;
`ifdef PS2_DEVICE_RESEND_EN
         resend_q    <= resend_d;
         tx_resend_q <= tx_resend_d;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_device.sv
// Self-checking bench for ps2_device: a behavioural PS/2 host drives the open-drain lines,
// decodes device frames and checks commands against a small reference model.
module tb_ps2_device;

   localparam int unsigned HP   = 8;
   localparam int unsigned IDLE = 24;

   logic       clk = 1'b0;
   logic       reset_low = 1'b0;
   logic       host_clk = 1'b1;
   logic       host_data = 1'b1;
   logic       ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
   logic       scan_code_valid = 1'b0;
   logic       scan_code_ready;
   logic [7:0] scan_code_byte = 8'h00;
   logic       command_valid;
   logic       command_ready = 1'b0;
   logic [7:0] command_byte;
   logic       error;
   logic       ps2_clk_line, ps2_data_line;

   // Wired-AND of host and device open-drain drivers.
   assign ps2_clk_line  = host_clk  & (ps2_clk_oe  ? ps2_clk_out  : 1'b1);
   assign ps2_data_line = host_data & (ps2_data_oe ? ps2_data_out : 1'b1);

   ps2_device #(.HALF_PERIOD(HP), .IDLE_CYCLES(IDLE)) dut (
      .clk             (clk),
      .reset_low       (reset_low),
      .ps2_clk_in      (ps2_clk_line),
      .ps2_clk_out     (ps2_clk_out),
      .ps2_clk_oe      (ps2_clk_oe),
      .ps2_data_in     (ps2_data_line),
      .ps2_data_out    (ps2_data_out),
      .ps2_data_oe     (ps2_data_oe),
      .scan_code_valid (scan_code_valid),
      .scan_code_ready (scan_code_ready),
      .scan_code_byte  (scan_code_byte),
      .command_valid   (command_valid),
      .command_ready   (command_ready),
      .command_byte    (command_byte),
      .error           (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int err_pulses = 0;
   int n_vec = 0;
   int n_err = 0;

   // Reference model of the command interface.
   logic       cmd_valid_exp = 1'b0;
   logic [7:0] cmd_byte_exp = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (error === 1'b1) err_pulses++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return ps2_clk_oe;
         1:       return ps2_data_oe;
         2:       return scan_code_ready;
         default: return command_valid;
      endcase
   endfunction

   // Bounded wait for a DUT output level; an expired budget shows up as a failed check.
   task automatic wait_sig(input string tag, input int sel, input logic val, input int budget);
      int n = 0;
      while (sig(sel) !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, {31'd0, sig(sel)}, {31'd0, val});
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, odd_par(b), b, 1'b0};
   endfunction

   task automatic offer(input logic [7:0] b);
      scan_code_byte  = b;
      scan_code_valid = 1'b1;
      wait_sig("offer_ready", 2, 1'b1, 4 * IDLE + 60 * HP);
      @(negedge clk);
      scan_code_valid = 1'b0;
   endtask

   // Host samples the data line on each falling PS/2 clock edge.
   task automatic recv_frame(input logic [7:0] b, input string tag);
      logic [10:0] got;
      got = '0;
      for (int i = 0; i < 11; i++) begin
         wait_sig("frame_clk_fall", 0, 1'b1, 2 * IDLE + 40 * HP);
         got[i] = ps2_data_line;
         wait_sig("frame_clk_rise", 0, 1'b0, 2 * HP);
      end
      check_eq(tag, {21'd0, got}, {21'd0, frame_of(b)});
   endtask

   task automatic host_send(input logic [7:0] b, input logic bad);
      logic [9:0] bits;
      int         e0;
      int         w;
      bits = {1'b1, odd_par(b) ^ bad, b};
      e0   = err_pulses;
      host_clk = 1'b0;
      tick(3 * HP);
      host_data = 1'b0;
      tick(2);
      host_clk = 1'b1;
      tick(5);
      host_data = bits[0];
      for (int i = 1; i < 10; i++) begin
         wait_sig("rx_clk_fall", 0, 1'b1, 3 * HP);
         host_data = bits[i];
         wait_sig("rx_clk_rise", 0, 1'b0, 2 * HP);
      end
      wait_sig("ack_start", 1, 1'b1, 4 * HP);
      w = 0;
      while (ps2_data_oe === 1'b1 && w < 10 * HP) begin
         tick(1);
         w++;
      end
      check_eq("ack_len", w, 2 * HP);
      if (!bad) begin
         cmd_valid_exp = 1'b1;
         cmd_byte_exp  = b;
      end
      check_eq("cmd_valid", {31'd0, command_valid}, {31'd0, cmd_valid_exp});
      check_eq("cmd_byte", {24'd0, command_byte}, {24'd0, cmd_byte_exp});
      tick(1);
      check_eq("err_pulses", err_pulses - e0, {31'd0, bad});
`ifdef PS2_DEVICE_RESEND_EN
      if (bad) recv_frame(8'hFE, "resend_frame");
`endif
   endtask

   task automatic consume();
      command_ready = 1'b1;
      tick(1);
      command_ready = 1'b0;
      cmd_valid_exp = 1'b0;
      check_eq("cmd_cleared", {31'd0, command_valid}, {31'd0, cmd_valid_exp});
   endtask

   initial begin
      int          c1;
      int          seen;
      logic [7:0]  b;
      tick(3);
      check_eq("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check_eq("rst_data_oe", {31'd0, ps2_data_oe}, 0);
      check_eq("rst_ready", {31'd0, scan_code_ready}, 0);
      check_eq("rst_cmd_valid", {31'd0, command_valid}, 0);
      check_eq("rst_error", {31'd0, error}, 0);
      check_eq("rst_lines_out", {30'd0, ps2_clk_out, ps2_data_out}, 0);
      reset_low = 1'b1;
      tick(1);
      check_eq("ready_after_rst", {31'd0, scan_code_ready}, 1);

      // Scan code 0x1C on an idle bus, with frame latency.
      offer(8'h1C);
      wait_sig("tx_start", 1, 1'b1, 2 * IDLE + 20);
      c1 = cyc;
      recv_frame(8'h1C, "frame_1c");
      wait_sig("ready_back", 2, 1'b1, 4 * HP);
      check_eq("tx_latency", cyc - c1, 22 * HP);

      // Host commands: good, bad parity, latest-wins overwrite.
      tick(IDLE);
      host_send(8'hED, 1'b0);
      consume();
      host_send(8'hED, 1'b1);
      host_send(8'h12, 1'b0);
      host_send(8'h34, 1'b0);
      consume();

      // Inhibit during data bit 3 of 0xF0: abort, then whole-frame retransmit.
      offer(8'hF0);
      wait_sig("f0_start", 1, 1'b1, 2 * IDLE + 20);
      for (int i = 0; i < 4; i++) begin
         wait_sig("f0_fall", 0, 1'b1, 2 * HP);
         wait_sig("f0_rise", 0, 1'b0, 2 * HP);
      end
      tick(1);
      host_clk = 1'b0;
      tick(HP + 4);
      check_eq("abort_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check_eq("abort_data_oe", {31'd0, ps2_data_oe}, 0);
      check_eq("abort_ready", {31'd0, scan_code_ready}, 0);
      tick(2 * HP);
      host_clk = 1'b1;
      recv_frame(8'hF0, "frame_f0_resent");
      wait_sig("f0_ready", 2, 1'b1, 4 * HP);

      // Inhibit into host request during HOLD; held byte follows the ACK.
      offer(8'hA7);
      wait_sig("a7_start", 1, 1'b1, 2 * IDLE + 20);
      for (int i = 0; i < 2; i++) begin
         wait_sig("a7_fall", 0, 1'b1, 2 * HP);
         wait_sig("a7_rise", 0, 1'b0, 2 * HP);
      end
      host_send(8'hFF, 1'b0);
      recv_frame(8'hA7, "frame_a7_after_cmd");
      wait_sig("a7_ready", 2, 1'b1, 4 * HP);
      consume();

      // Randomised mix of scan codes, commands and consumption.
      for (int k = 0; k < 10; k++) begin
         b = 8'($urandom);
         case ($urandom_range(0, 2))
            0: begin
               offer(b);
               recv_frame(b, "rand_frame");
               wait_sig("rand_ready", 2, 1'b1, 4 * HP);
            end
            1: host_send(b, ($urandom_range(0, 3) == 0));
            default: if (cmd_valid_exp) consume();
         endcase
         tick($urandom_range(0, IDLE));
      end

      // Asynchronous reset in the middle of a frame.
      offer(8'h33);
      wait_sig("33_start", 1, 1'b1, 2 * IDLE + 20);
      tick(3);
      reset_low = 1'b0;
      #1;
      check_eq("async_rst_data_oe", {31'd0, ps2_data_oe}, 0);
      check_eq("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check_eq("async_rst_cmd_valid", {31'd0, command_valid}, 0);
      cmd_valid_exp = 1'b0;
      tick(2);
      reset_low = 1'b1;
      tick(1);
      check_eq("ready_after_mid_rst", {31'd0, scan_code_ready}, 1);
      seen = 0;
      repeat (2 * IDLE + 4 * HP) begin
         tick(1);
         if (ps2_data_oe === 1'b1) seen++;
      end
      check_eq("no_tx_after_rst", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
